// File: rtl/pack.sv
// Shared definitions for the execute-stage multiply/divide unit.
package pack;

    typedef enum logic [2:0] {
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } mulDivOp_;

    function automatic logic isDivide(input mulDivOp_ op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic returnsQuotient(input mulDivOp_ op);
        return op inside {DIV, DIVU};
    endfunction

endpackage

// File: rtl/div_step.sv
// Combinational restoring shift-subtract slice: retires STEPS quotient bits.
module div_step #(
    parameter int XLEN  = 32,
    parameter int STEPS = 1
) (
    input  logic [XLEN-1:0] remainderIn,
    input  logic [XLEN-1:0] quotientIn,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] remainderOut,
    output logic [XLEN-1:0] quotientOut
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // Dividend bits leave quotientOut at the top while quotient bits enter at the bottom.
    always_comb begin
        remainderOut = remainderIn;
        quotientOut  = quotientIn;
        shifted      = '0;
        trial        = '0;
        for (int i = 0; i < STEPS; i++) begin
            shifted      = {remainderOut, quotientOut[XLEN-1]};
            trial        = shifted - {1'b0, divisor};
            quotientOut  = {quotientOut[XLEN-2:0], ~trial[XLEN]};
            remainderOut = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        end
    end

endmodule

// File: rtl/execute_muldiv.sv
// Iterative multiply/divide unit: shift-add multiplier, shift-subtract divider on magnitudes.
module execute_muldiv
    import pack::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4,
    parameter int DIV_BITS = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            startValid,
    input  mulDivOp_        operation,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic [4:0]      destinationIn,
    input  logic            flush,
    input  logic            stall,
    output logic            busy,
    output logic            resultValid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      destinationOut
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int MUL_CYCLES = XLEN / MUL_BITS;
    localparam int DIV_CYCLES = XLEN / DIV_BITS;
    localparam int CW         = $clog2(XLEN + 1);

    state_t            state;
    mulDivOp_          opLatched;
    logic [CW-1:0]     cycleCount;
    logic [2*XLEN-1:0] accumulator, multiplicand, mulNext, mulProduct;
    logic [XLEN-1:0]   multiplier, remainder, quotient, divisor;
    logic [XLEN-1:0]   remainderNext, quotientNext, quotientFinal, remainderFinal;
    logic [XLEN-1:0]   mulResult, divResult;
    logic              negQuotient, negRemainder;

    logic              sign1, sign2, divZero, divOverflow;
    logic [XLEN-1:0]   mag1, mag2, specialResult;

    assign busy = (state != IDLE);

    function automatic logic [2*XLEN-1:0] partialProduct(input logic [2*XLEN-1:0] mc,
                                                         input logic [MUL_BITS-1:0] bits);
        partialProduct = '0;
        for (int i = 0; i < MUL_BITS; i++)
            if (bits[i]) partialProduct = partialProduct + (mc << i);
    endfunction

    // Decode of the incoming request: operand signs, magnitudes and the 1-cycle divide cases.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sign1 = 1'b0;
        sign2 = 1'b0;
        case (operation)
            MULH, DIV, REM: begin
                sign1 = operand1[XLEN-1];
                sign2 = operand2[XLEN-1];
            end
            MULHSU:  sign1 = operand1[XLEN-1];
            default: ;
        endcase
        mag1        = sign1 ? -operand1 : operand1;
        mag2        = sign2 ? -operand2 : operand2;
        divZero     = (operand2 == '0);
        divOverflow = (operation inside {DIV, REM}) && (operand1 == {1'b1, {(XLEN-1){1'b0}}})
                      && (operand2 == '1);
        if (divZero)
            specialResult = returnsQuotient(operation) ? '1 : operand1;
        else
            specialResult = (operation == DIV) ? operand1 : '0;
    end

    div_step #(.XLEN(XLEN), .STEPS(DIV_BITS)) u_div_step (
        .remainderIn  (remainder),
        .quotientIn   (quotient),
        .divisor      (divisor),
        .remainderOut (remainderNext),
        .quotientOut  (quotientNext)
    );

    // Final values are formed from the last iteration so the result lands on the DONE edge.
    always_comb begin
        mulNext        = accumulator + partialProduct(multiplicand, multiplier[MUL_BITS-1:0]);
        mulProduct     = negQuotient ? -mulNext : mulNext;
        mulResult      = (opLatched == MUL) ? mulProduct[XLEN-1:0] : mulProduct[2*XLEN-1:XLEN];
        quotientFinal  = negQuotient ? -quotientNext : quotientNext;
        remainderFinal = negRemainder ? -remainderNext : remainderNext;
        divResult      = returnsQuotient(opLatched) ? quotientFinal : remainderFinal;
    end

    // NOTE: the datapath registers are reset too, so every output is a known 0 out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            opLatched      <= MUL;
            cycleCount     <= '0;
            accumulator    <= '0;
            multiplicand   <= '0;
            multiplier     <= '0;
            remainder      <= '0;
            quotient       <= '0;
            divisor        <= '0;
            negQuotient    <= 1'b0;
            negRemainder   <= 1'b0;
            resultValid    <= 1'b0;
            result         <= '0;
            destinationOut <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge.
            case (state)
                IDLE: if (startValid && !flush) begin
                    opLatched      <= operation;
                    destinationOut <= destinationIn;
                    if (isDivide(operation) && (divZero || divOverflow)) begin
                        state       <= DONE;
                        resultValid <= 1'b1;
                        result      <= specialResult;
                    end else begin
                        state        <= RUN;
                        cycleCount   <= isDivide(operation) ? CW'(DIV_CYCLES - 1)
                                                            : CW'(MUL_CYCLES - 1);
                        accumulator  <= '0;
                        multiplicand <= {{XLEN{1'b0}}, mag1};
                        multiplier   <= mag2;
                        remainder    <= '0;
                        quotient     <= mag1;
                        divisor      <= mag2;
                        negQuotient  <= sign1 ^ sign2;
                        negRemainder <= sign1;
                    end
                end
                RUN: if (flush) begin
                    state <= IDLE;
                end else begin
                    accumulator  <= mulNext;
                    multiplicand <= multiplicand << MUL_BITS;
                    multiplier   <= multiplier >> MUL_BITS;
                    remainder    <= remainderNext;
                    quotient     <= quotientNext;
                    cycleCount   <= cycleCount - CW'(1);
                    if (cycleCount == '0) begin
                        state       <= DONE;
                        resultValid <= 1'b1;
                        result      <= isDivide(opLatched) ? divResult : mulResult;
                    end
                end
                DONE: if (flush || !stall) begin
                    state       <= IDLE;
                    resultValid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/execute_muldiv.md
EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 Parameter MUL_BITS, default 4, multiplier bits retired per cycle; must divide XLEN.
REQ-003 Parameter DIV_BITS, default 1, quotient bits retired per cycle; legal values 1, 2, 4.
REQ-004 The port list SHALL be:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- startValid  input  1  operation request.
- operation  input  mulDivOp_  one of MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- operand1  input  XLEN  rs1 value, forwarding already resolved.
- operand2  input  XLEN  rs2 value, forwarding already resolved.
- destinationIn  input  5  rd tag.
- flush  input  1  kill the in-flight operation.
- stall  input  1  downstream cannot accept the result.
- busy  output  1  unit is occupied; upstream holds its instruction.
- resultValid  output  1  result is present.
- result  output  XLEN  final value.
- destinationOut  output  5  rd tag of the result.

Function
REQ-005 The unit SHALL have three states: IDLE, RUN and DONE. busy SHALL equal (state != IDLE).
REQ-006 A request SHALL be accepted only in IDLE with startValid=1 and flush=0. On acceptance the unit latches the operands, the operation and destinationIn.
REQ-007 Multiply latency: RUN SHALL last XLEN/MUL_BITS cycles, then DONE. resultValid rises XLEN/MUL_BITS+1 edges after acceptance.
REQ-008 Divide latency: RUN SHALL last XLEN/DIV_BITS cycles, then DONE.
REQ-009 Multiply products SHALL be 2*XLEN bits wide.
- MUL returns the low XLEN bits.
- MULH, MULHSU and MULHU return the high XLEN bits.
- Signedness: MULH signed x signed; MULHSU signed x unsigned; MULHU unsigned x unsigned.
REQ-010 Signed divide: magnitudes are divided. The quotient sign is the XOR of the operand signs. The remainder sign follows the dividend.
REQ-011 Divide by zero SHALL skip RUN and go straight from acceptance to DONE (1-cycle latency).
- DIV/DIVU return all ones.
- REM/REMU return operand1.
REQ-012 Signed overflow (DIV/REM with operand1 = most-negative and operand2 = -1) SHALL take the same 1-cycle path. DIV returns operand1; REM returns 0.
REQ-013 In DONE, resultValid=1 and result/destinationOut SHALL hold stable while stall=1. When stall=0, the unit returns to IDLE on the next edge.
REQ-014 No new request is accepted in DONE; back-to-back operations therefore have one IDLE cycle between them.
REQ-015 flush=1 in RUN or DONE SHALL force IDLE on the next edge.
- resultValid is not asserted for the killed operation.
- flush has priority over stall and over startValid.
REQ-016 startValid while busy=1 SHALL be ignored, with no state change.
REQ-017 resultValid SHALL be 0 in IDLE and RUN. result is don't-care when resultValid=0.

Reset
REQ-018 reset=0 SHALL asynchronously force:
- state to IDLE;
- busy, resultValid, result and destinationOut to 0;
- all datapath registers to 0.
REQ-019 Reset asserted mid-operation SHALL discard the operation. The first edge after release sees IDLE.

Structure
REQ-020 The mulDivOp_ enum SHALL live in the shared package pack. The state enum stays local to the module.
REQ-021 The shift-subtract divider SHALL be one sub-module, div_step: it is combinational and retires DIV_BITS quotient bits. It is instantiated once.
REQ-022 The multiplier SHALL be shift-add over MUL_BITS partial products. No vendor DSP primitives are instantiated.

Verification
REQ-023 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; resultValid 9 edges after acceptance (XLEN=32, MUL_BITS=4).
REQ-024 MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-025 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, both at 33 edges (DIV_BITS=1). DIVU 100 / 7 -> 14 and REMU -> 2.
REQ-026 DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, 1 edge after acceptance. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, 1 edge.
REQ-027 DIV started, flush at RUN cycle 10 -> busy=0 next edge, resultValid never rises, and the next request completes correctly.
REQ-028 stall=1 for 5 cycles in DONE -> result and destinationOut stable, busy=1. stall drops -> IDLE next edge. reset=0 pulsed mid-RUN -> all outputs 0 immediately.
